uart_tx_arbiter: RTL and testbench

- Shares the single memory-mapped UART transmitter between two byte-stream requesters, e.g. the CPU console path and the debug path.
- Arbitrates round-robin between them.
- Sequences the UART register protocol for each byte: write TX_DATA_BUF, poll UART_CTRL.TI (bit 1), then clear TI.
- Sits between the requesters and the UART slave port, in place of direct bus writes.

---
 rtl/uart_tx_arbiter.sv | 130 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one memory-mapped UART transmitter between two byte-stream
// requesters. Requesters are served round-robin; for each accepted byte the
// block writes TX_DATA_BUF, polls CTRL until TI (bit 1) is set, then writes
// CTRL back with TI cleared and every other bit (including RI) preserved.
//
// Parameters:
//   UART_BASE    base address of the UART block (CTRL = +0x0, TX_DATA_BUF = +0x4)
//   TIMEOUT_MAX  number of POLL cycles allowed before the byte is abandoned
//
// Ports:
//   sys_clk, sys_reset           clock, asynchronous active-high reset
//   req0_valid_i/data_i/ready_o  requester 0 byte handshake
//   req1_valid_i/data_i/ready_o  requester 1 byte handshake
//   uart_wr_en_o/addr_o/data_o   UART write port (registered)
//   uart_rd_addr_o               UART read address (constant CTRL address)
//   uart_rd_data_i               UART read data, one cycle after the address
//   busy_o                       a transfer is in progress
//   grant_o                      requester currently or last served
//   timeout_o                    sticky POLL timeout flag, cleared by reset
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter logic [31:0] UART_BASE   = 32'h0,
    parameter logic [31:0] TIMEOUT_MAX = 32'd1_000_000
) (
    input  logic        sys_clk,
    input  logic        sys_reset,
    input  logic        req0_valid_i,
    input  logic [7:0]  req0_data_i,
    output logic        req0_ready_o,
    input  logic        req1_valid_i,
    input  logic [7:0]  req1_data_i,
    output logic        req1_ready_o,
    output logic        uart_wr_en_o,
    output logic [31:0] uart_wr_addr_o,
    output logic [31:0] uart_wr_data_o,
    output logic [31:0] uart_rd_addr_o,
    input  logic [31:0] uart_rd_data_i,
    output logic        busy_o,
    output logic        grant_o,
    output logic        timeout_o
);

    localparam logic [31:0] CTRL_ADDR  = UART_BASE;
    localparam logic [31:0] TXBUF_ADDR = UART_BASE + 32'd4;
    localparam logic [31:0] TI_MASK    = 32'h0000_0002;

    typedef enum logic [1:0] {IDLE, WRITE, POLL, CLEAR} state_t;

    state_t      state;
    logic [31:0] poll_cnt;
    logic        any_valid;
    logic        pick1;
    logic        accept;

    // CTRL is the only register ever read, so the read address never moves.
    assign uart_rd_addr_o = CTRL_ADDR;

    // NOTE: every signal driven here is assigned on every pass through the
    // block, so no storage (latch) is inferred.
    always_comb begin
        any_valid    = req0_valid_i | req1_valid_i;
        // Requester 1 wins when it is alone, or when both ask and 0 went last.
        pick1        = req1_valid_i & (~req0_valid_i | ~grant_o);
        // Gated by reset so ready stays low while reset is held.
        accept       = (state == IDLE) & any_valid & ~sys_reset;
        req0_ready_o = accept & ~pick1;
        req1_ready_o = accept &  pick1;
        busy_o       = (state != IDLE);
    end

    // NOTE: all state and registered outputs use non-blocking assignments so
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            state          <= IDLE;
            uart_wr_en_o   <= 1'b0;
            uart_wr_addr_o <= 32'h0;
            uart_wr_data_o <= 32'h0;
            grant_o        <= 1'b1;
            timeout_o      <= 1'b0;
            poll_cnt       <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        grant_o        <= pick1;
                        // The write-data register doubles as the byte latch.
                        uart_wr_en_o   <= 1'b1;
                        uart_wr_addr_o <= TXBUF_ADDR;
                        uart_wr_data_o <= {24'h0, pick1 ? req1_data_i : req0_data_i};
                        state          <= WRITE;
                    end
                end

                WRITE: begin
                    uart_wr_en_o <= 1'b0;
                    poll_cnt     <= 32'h0;
                    state        <= POLL;
                end

                POLL: begin
                    // poll_cnt == 0 marks the first POLL cycle, whose read data
                    // still belongs to an address issued before the TX write.
                    if ((poll_cnt != 32'h0) && uart_rd_data_i[1]) begin
                        uart_wr_en_o   <= 1'b1;
                        uart_wr_addr_o <= CTRL_ADDR;
                        uart_wr_data_o <= uart_rd_data_i & ~TI_MASK;
                        state          <= CLEAR;
                    end else if (poll_cnt == TIMEOUT_MAX - 32'd1) begin
                        timeout_o <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        poll_cnt <= poll_cnt + 32'd1;
                    end
                end

                CLEAR: begin
                    uart_wr_en_o <= 1'b0;
                    state        <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Drives uart_tx_arbiter against a small UART register model. Each byte is
// predicted from the arbitration and protocol rules: the round-robin winner,
// the TX_DATA_BUF write one cycle after acceptance, the CLEAR write at a cycle
// derived from the model's TI delay plus the registered read latency, and the
// CTRL value written back with TI removed.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam logic [31:0] BASE = 32'h4000_0100;
    localparam int          TO   = 16;

    logic        sys_clk;
    logic        sys_reset;
    logic        req0_valid_i;
    logic [7:0]  req0_data_i;
    logic        req0_ready_o;
    logic        req1_valid_i;
    logic [7:0]  req1_data_i;
    logic        req1_ready_o;
    logic        uart_wr_en_o;
    logic [31:0] uart_wr_addr_o;
    logic [31:0] uart_wr_data_o;
    logic [31:0] uart_rd_addr_o;
    logic [31:0] uart_rd_data_i;
    logic        busy_o;
    logic        grant_o;
    logic        timeout_o;

    uart_tx_arbiter #(
        .UART_BASE  (BASE),
        .TIMEOUT_MAX(32'(TO))
    ) dut (
        .sys_clk       (sys_clk),
        .sys_reset     (sys_reset),
        .req0_valid_i  (req0_valid_i),
        .req0_data_i   (req0_data_i),
        .req0_ready_o  (req0_ready_o),
        .req1_valid_i  (req1_valid_i),
        .req1_data_i   (req1_data_i),
        .req1_ready_o  (req1_ready_o),
        .uart_wr_en_o  (uart_wr_en_o),
        .uart_wr_addr_o(uart_wr_addr_o),
        .uart_wr_data_o(uart_wr_data_o),
        .uart_rd_addr_o(uart_rd_addr_o),
        .uart_rd_data_i(uart_rd_data_i),
        .busy_o        (busy_o),
        .grant_o       (grant_o),
        .timeout_o     (timeout_o)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int checks   = 0;
    int failures = 0;

    // Reference state kept by the bench
    int          m_last;       // requester served last (round-robin pointer)
    bit          exp_to;       // expected sticky timeout flag
    logic [31:0] ctrl_seed;    // CTRL contents loaded into the UART model

    // UART model: registered read, TI rises ti_delay+1 cycles after the TX
    // write is seen (never when ti_delay < 0), CTRL write replaces CTRL.
    logic [31:0] ctrl;
    int          ti_delay;
    int          ti_timer;
    bit          ti_pending;
    int          load_req;
    int          load_ack;

    initial begin
        ctrl       = 32'h0;
        ti_pending = 1'b0;
        ti_timer   = 0;
        load_ack   = 0;
        uart_rd_data_i = 32'h0;
    end

    always @(posedge sys_clk) begin
        uart_rd_data_i <= (uart_rd_addr_o == BASE) ? ctrl : 32'h0;
        if (load_req != load_ack) begin
            ctrl     <= ctrl_seed;
            load_ack <= load_req;
        end else if (uart_wr_en_o && uart_wr_addr_o == BASE) begin
            ctrl <= uart_wr_data_o;
        end else if (ti_pending && ti_timer == 0) begin
            ctrl[1] <= 1'b1;
        end
        if (uart_wr_en_o && uart_wr_addr_o == BASE + 32'd4) begin
            ti_pending <= (ti_delay >= 0);
            ti_timer   <= ti_delay;
        end else if (ti_pending) begin
            if (ti_timer == 0) ti_pending <= 1'b0;
            else               ti_timer   <= ti_timer - 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ctrl(input logic [31:0] seed);
        ctrl_seed = seed;
        load_req++;
    endtask

    // One byte transfer. Called in an IDLE cycle before its rising edge; returns
    // at the falling edge of the first IDLE cycle after the transfer.
    task automatic run_byte(input bit v0, input bit v1, input logic [7:0] d0,
                            input logic [7:0] d1, input int dly, input bit hold,
                            input bit stale, input bit expect_to);
        int          w;
        int          k;
        int          n_wr;
        int          bad_ready;
        int          clear_k;
        int          end_k;
        logic        g1;
        int          wr_k[2];
        logic [31:0] wr_a[2];
        logic [31:0] wr_d[2];
        ti_delay     = dly;
        req0_valid_i = v0;
        req1_valid_i = v1;
        req0_data_i  = d0;
        req1_data_i  = d1;
        w = (v0 && v1) ? (1 - m_last) : (v1 ? 1 : 0);
        #1;
        check("accept_ready0", req0_ready_o, (w == 0));
        check("accept_ready1", req1_ready_o, (w == 1));
        m_last = w;
        @(posedge sys_clk);
        #1;
        if (!hold) begin
            req0_valid_i = 1'b0;
            req1_valid_i = 1'b0;
            req0_data_i  = 8'hxx;
            req1_data_i  = 8'hxx;
        end
        n_wr      = 0;
        bad_ready = 0;
        g1        = 1'bx;
        for (k = 1; k < 64; k++) begin
            @(negedge sys_clk);
            if (!busy_o) break;
            if (k == 1) g1 = grant_o;
            if (req0_ready_o || req1_ready_o) bad_ready++;
            if (uart_wr_en_o) begin
                if (n_wr < 2) begin
                    wr_k[n_wr] = k;
                    wr_a[n_wr] = uart_wr_addr_o;
                    wr_d[n_wr] = uart_wr_data_o;
                end
                n_wr++;
            end
        end
        clear_k = stale ? 4 : 5 + dly;
        end_k   = expect_to ? TO + 2 : clear_k + 1;
        exp_to  = exp_to | expect_to;
        check("grant", g1, w[0]);
        check("busy_fall_cycle", k, end_k);
        check("ready_outside_idle", bad_ready, 0);
        check("write_count", n_wr, expect_to ? 1 : 2);
        check("txbuf_cycle", wr_k[0], 1);
        check("txbuf_addr", wr_a[0], BASE + 32'd4);
        check("txbuf_data", wr_d[0], {24'h0, (w == 1) ? d1 : d0});
        if (!expect_to) begin
            check("clear_cycle", wr_k[1], clear_k);
            check("clear_addr", wr_a[1], BASE);
            check("clear_data", wr_d[1], ctrl_seed & ~32'h2);
        end
        check("timeout_flag", timeout_o, exp_to);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        load_req     = 0;
        ti_delay     = -1;
        ctrl_seed    = 32'h0;
        m_last       = 1;
        exp_to       = 1'b0;
        // Reset with both requests raised: ready must stay low.
        sys_reset    = 1'b1;
        req0_valid_i = 1'b1;
        req1_valid_i = 1'b1;
        req0_data_i  = 8'h00;
        req1_data_i  = 8'h00;
        repeat (2) @(negedge sys_clk);
        check("rst_ready0", req0_ready_o, 1'b0);
        check("rst_ready1", req1_ready_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_wr_en", uart_wr_en_o, 1'b0);
        check("rst_wr_addr", uart_wr_addr_o, 32'h0);
        check("rst_wr_data", uart_wr_data_o, 32'h0);
        check("rst_rd_addr", uart_rd_addr_o, BASE);
        check("rst_grant", grant_o, 1'b1);
        check("rst_timeout", timeout_o, 1'b0);
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        #2 sys_reset = 1'b0;
        @(posedge sys_clk);
        #1;

        // Contention: both held, grants alternate starting with requester 0.
        set_ctrl(32'h0);
        for (int i = 0; i < 4; i++)
            run_byte(1, 1, 8'hA1, 8'hB2, i % 3, 1, 0, 0);

        // Single byte from requester 0.
        run_byte(1, 0, 8'h55, 8'h00, 1, 0, 0, 0);

        // RI preserved: CTRL = 0x3 at completion, CLEAR writes 0x1.
        set_ctrl(32'h1);
        run_byte(0, 1, 8'h3C, 8'hC3, 2, 0, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 10; i++) begin
            bit       v0;
            bit       v1;
            int       sel;
            sel = $urandom_range(0, 2);
            v0  = (sel != 1);
            v1  = (sel != 0);
            set_ctrl($urandom & ~32'h2);
            run_byte(v0, v1, 8'($urandom), 8'($urandom), $urandom_range(0, 6),
                     1'($urandom), 0, 0);
        end

        // Stale TI already set: accepted after the ignored first POLL cycle.
        set_ctrl(32'h0000_8002);
        run_byte(1, 0, 8'h77, 8'h00, -1, 0, 1, 0);

        // Timeout with TI stuck low, then a normal byte.
        set_ctrl(32'h0);
        run_byte(0, 1, 8'h00, 8'h99, -1, 0, 0, 1);
        run_byte(1, 0, 8'h42, 8'h00, 0, 0, 0, 0);

        // Reset while polling: outputs return at once, no CLEAR write.
        ti_delay     = -1;
        req0_valid_i = 1'b1;
        req0_data_i  = 8'hE7;
        @(posedge sys_clk);
        #1 req0_valid_i = 1'b0;
        repeat (3) @(posedge sys_clk);
        check("poll_busy", busy_o, 1'b1);
        req1_valid_i = 1'b1;
        #2 sys_reset = 1'b1;
        #1;
        check("mid_rst_busy", busy_o, 1'b0);
        check("mid_rst_wr_en", uart_wr_en_o, 1'b0);
        check("mid_rst_wr_addr", uart_wr_addr_o, 32'h0);
        check("mid_rst_wr_data", uart_wr_data_o, 32'h0);
        check("mid_rst_grant", grant_o, 1'b1);
        check("mid_rst_timeout", timeout_o, 1'b0);
        check("mid_rst_ready1", req1_ready_o, 1'b0);
        @(negedge sys_clk);
        check("mid_rst_wr_en_hold", uart_wr_en_o, 1'b0);
        req1_valid_i = 1'b0;
        m_last = 1;
        exp_to = 1'b0;
        #2 sys_reset = 1'b0;

        // Requester 1 alone is served first after reset; then fairness resumes.
        run_byte(0, 1, 8'h00, 8'h5A, 1, 0, 0, 0);
        run_byte(1, 1, 8'h11, 8'h22, 0, 0, 0, 0);

        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        repeat (2) @(posedge sys_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
